// File: rtl/spdif_subframe_unpack.sv
// S/PDIF subframe unpacker: collects the 28 decoded bits after each preamble, checks even
// parity, queues {sample, channel, V, U} in a first-word-fall-through FIFO and assembles the channel-status block.
module spdif_subframe_unpack #(
  parameter int SAMPLE_W   = 20,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CS_CH      = 0,
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pre_valid,
  input  logic [1:0]          pre_type,
  input  logic                vin,
  input  logic                din,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic [CHW-1:0]      out_ch,
  output logic                out_v,
  output logic                out_u,
  output logic                cs_valid,
  output logic [191:0]        cs_data,
  output logic                cs_err,
  output logic                short_err,
  output logic [15:0]         par_err_cnt,
  output logic [15:0]         ovf_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = SAMPLE_W + CHW + 2;
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CHW-1:0] CS_IDX  = CHW'(CS_CH);
  localparam logic [CHW-1:0] CH_MAX  = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;
  state_t state_q, state_d;

  logic [4:0]     bitcnt_q;
  logic [27:0]    sr_q;
  logic [CHW-1:0] ch_q;
  logic [7:0]     fidx_q;
  logic           block_ok_q, armed_q, csv_seen_q;
  logic [191:0]   shadow_q, shadow_d, cs_data_q;
  logic           cs_valid_q, cs_err_q, short_err_q;
  logic [15:0]    par_err_cnt_q, ovf_cnt_q;

  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           empty_q, full_q;

  logic pv_ok, is_b, is_m, is_w;
  logic do_shift, do_commit, trunc;
  logic parity_ok, cs_slot, last_frame, cs_done, cs_bad_last, b_err;
  logic rd_en, wr_req, wr_en, ovf;
  logic [EW-1:0] wr_word, head;

  assign pv_ok = pre_valid && (pre_type != 2'd3);
  assign is_b  = pv_ok && (pre_type == 2'd0);
  assign is_m  = pv_ok && (pre_type == 2'd1);
  assign is_w  = pv_ok && (pre_type == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pv_ok) state_d = S_SHIFT;
      S_SHIFT:  if (pv_ok) state_d = S_SHIFT;
                else if (vin && bitcnt_q == 5'd27) state_d = S_COMMIT;
      S_COMMIT: state_d = pv_ok ? S_SHIFT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A preamble always wins over a coincident data strobe.
  always_comb begin
    do_shift  = (state_q == S_SHIFT) && vin && !pv_ok;
    do_commit = (state_q == S_COMMIT);
    trunc     = (state_q == S_SHIFT) && pv_ok;
  end

  assign parity_ok   = ~^sr_q;
  assign cs_slot     = do_commit && (ch_q == CS_IDX);
  assign last_frame  = cs_slot && (fidx_q == 8'd191) && block_ok_q;
  assign cs_done     = last_frame && parity_ok;
  assign cs_bad_last = last_frame && !parity_ok;
  assign b_err       = is_b && armed_q && !(csv_seen_q || cs_done);

  always_comb begin
    shadow_d = shadow_q;
    if (cs_slot) shadow_d[fidx_q] = sr_q[26];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q      <= '0;
      sr_q          <= '0;
      ch_q          <= '0;
      fidx_q        <= '0;
      block_ok_q    <= 1'b0;
      armed_q       <= 1'b0;
      csv_seen_q    <= 1'b0;
      shadow_q      <= '0;
      cs_data_q     <= '0;
      cs_valid_q    <= 1'b0;
      cs_err_q      <= 1'b0;
      short_err_q   <= 1'b0;
      par_err_cnt_q <= '0;
      ovf_cnt_q     <= '0;
    end else begin
      if (pv_ok)         bitcnt_q <= '0;
      else if (do_shift) bitcnt_q <= bitcnt_q + 5'd1;
      if (do_shift) sr_q <= {din, sr_q[27:1]};

      if (is_b || is_m)                ch_q <= '0;
      else if (is_w && ch_q != CH_MAX) ch_q <= ch_q + 1'b1;

      if (is_b)                          fidx_q <= '0;
      else if (is_m && fidx_q != 8'd191) fidx_q <= fidx_q + 8'd1;

      // B opens a new block even if the subframe committing alongside it was bad.
      if (is_b) block_ok_q <= 1'b1;
      else if ((is_m && fidx_q == 8'd191) || (do_commit && !parity_ok)) block_ok_q <= 1'b0;

      if (is_b) armed_q <= 1'b1;
      if (is_b)         csv_seen_q <= 1'b0;
      else if (cs_done) csv_seen_q <= 1'b1;

      shadow_q <= shadow_d;
      if (cs_done) cs_data_q <= shadow_d;
      cs_valid_q  <= cs_done;
      cs_err_q    <= cs_bad_last || b_err;
      short_err_q <= trunc;

      if (do_commit && !parity_ok && par_err_cnt_q != 16'hFFFF) par_err_cnt_q <= par_err_cnt_q + 16'd1;
      if (ovf && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  // A full FIFO still accepts a write when its head leaves in the same cycle.
  assign rd_en   = out_valid && out_ready;
  assign wr_req  = do_commit && parity_ok;
  assign wr_en   = wr_req && (!full_q || rd_en);
  assign ovf     = wr_req && !wr_en;
  assign wr_word = {sr_q[23 -: SAMPLE_W], ch_q, sr_q[24], sr_q[25]};

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (!wr_en && rd_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = !empty_q;
  assign out_data    = out_valid ? head[EW-1 -: SAMPLE_W] : '0;
  assign out_ch      = out_valid ? head[CHW+1:2] : '0;
  assign out_v       = out_valid && head[1];
  assign out_u       = out_valid && head[0];
  assign cs_valid    = cs_valid_q;
  assign cs_data     = cs_data_q;
  assign cs_err      = cs_err_q;
  assign short_err   = short_err_q;
  assign par_err_cnt = par_err_cnt_q;
  assign ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_spdif_subframe_unpack.sv
// Randomised bench for spdif_subframe_unpack: a transaction-level model predicts every
// delivered word, channel-status block, pulse count and counter value.
module tb_spdif_subframe_unpack;
  localparam int SW = 20, NCH = 4, DEPTH = 16, CSC = 0;

  typedef struct packed { logic [19:0] d; logic [1:0] ch; logic v; logic u; } word_t;

  logic clk = 1'b0, rst, pre_valid, vin, din, out_ready;
  logic [1:0] pre_type;
  logic out_valid, out_v, out_u, cs_valid, cs_err, short_err;
  logic [19:0] out_data;
  logic [1:0] out_ch;
  logic [191:0] cs_data;
  logic [15:0] par_err_cnt, ovf_cnt;

  spdif_subframe_unpack #(.SAMPLE_W(SW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .CS_CH(CSC)) dut (
    .clk(clk), .rst(rst), .pre_valid(pre_valid), .pre_type(pre_type), .vin(vin), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_v(out_v), .out_u(out_u), .cs_valid(cs_valid), .cs_data(cs_data), .cs_err(cs_err),
    .short_err(short_err), .par_err_cnt(par_err_cnt), .ovf_cnt(ovf_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // reference model state
  int m_ch, m_fidx, m_par, m_ovf;
  bit m_block_ok, m_armed, m_csv, m_in_sub;
  int exp_short = 0, exp_cs_err = 0, exp_cs_valid = 0;
  logic [191:0] m_shadow;
  word_t exp_q[$];
  logic [191:0] cs_q[$];
  // observed
  word_t got_log[$];
  int n_cs_valid = 0, n_cs_err = 0, n_short = 0;
  bit rdy_rand = 0, rdy_fixed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [27:0] mk(input logic [23:0] a, input logic v, input logic u, input logic c);
    logic [26:0] b;
    b = {c, u, v, a};
    return {^b, b};
  endfunction

  function automatic void model_reset();
    exp_q.delete(); cs_q.delete();
    m_ch = 0; m_fidx = 0; m_par = 0; m_ovf = 0;
    m_block_ok = 0; m_armed = 0; m_csv = 0; m_in_sub = 0; m_shadow = '0;
  endfunction

  function automatic void model_pre(input logic [1:0] t);
    if (t == 2'd3) return;
    if (m_in_sub) exp_short++;
    if (t == 2'd0) begin
      if (m_armed && !m_csv) exp_cs_err++;
      m_ch = 0; m_fidx = 0; m_block_ok = 1; m_armed = 1; m_csv = 0;
    end else if (t == 2'd1) begin
      m_ch = 0;
      if (m_fidx == 191) m_block_ok = 0; else m_fidx++;
    end else if (m_ch < NCH - 1) m_ch++;
    m_in_sub = 1;
  endfunction

  function automatic void model_commit(input logic [27:0] w);
    bit last;
    m_in_sub = 0;
    if (m_ch == CSC) m_shadow[m_fidx] = w[26];
    last = (m_ch == CSC) && (m_fidx == 191) && m_block_ok;
    if (^w) begin
      m_par++;
      if (last) exp_cs_err++;
      m_block_ok = 0;
    end else begin
      if (last) begin exp_cs_valid++; cs_q.push_back(m_shadow); m_csv = 1; end
      if (exp_q.size() >= DEPTH) m_ovf++;
      else exp_q.push_back('{d: w[23 -: SW], ch: m_ch[1:0], v: w[24], u: w[25]});
    end
  endfunction

  task automatic pre(input logic [1:0] t);
    pre_valid = 1'b1; pre_type = t; model_pre(t);
    @(posedge clk); #1;
    pre_valid = 1'b0; pre_type = 2'd3;
  endtask

  task automatic send_bits(input logic [27:0] w, input int n, input bit fast_end);
    for (int i = 0; i < n; i++) begin
      vin = 1'b1; din = w[i];
      @(posedge clk); #1;
      vin = 1'b0; din = 1'b0;
      if (i == 27 && m_in_sub) model_commit(w);
      if (!(fast_end && i == n - 1)) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic sub(input logic [1:0] t, input logic c);
    pre(t);
    send_bits(mk(24'($urandom()), 1'($urandom()), 1'($urandom()), c), 28, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  // compare process
  initial begin
    word_t got, prev, e;
    bit hold_prev;
    hold_prev = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (rst) hold_prev = 0;
      else begin
        got = '{d: out_data, ch: out_ch, v: out_v, u: out_u};
        if (hold_prev) begin
          checks++;
          if (!out_valid || got != prev) begin
            errors++;
            $display("FAIL hold got v=%b %h exp %h", out_valid, got, prev);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL word unexpected got d=%h ch=%0d v=%b u=%b", got.d, got.ch, got.v, got.u);
          end else begin
            e = exp_q.pop_front();
            if (got != e) begin
              errors++;
              $display("FAIL word got d=%h ch=%0d v=%b u=%b exp d=%h ch=%0d v=%b u=%b",
                       got.d, got.ch, got.v, got.u, e.d, e.ch, e.v, e.u);
            end
          end
          got_log.push_back(got);
        end
        if (cs_valid) begin
          n_cs_valid++;
          checks++;
          if (cs_q.size() == 0) begin
            errors++;
            $display("FAIL cs_block unexpected cs_valid got=%h", cs_data);
          end else if (cs_data !== cs_q[0]) begin
            errors++;
            $display("FAIL cs_block got=%h exp=%h", cs_data, cs_q[0]);
            void'(cs_q.pop_front());
          end else void'(cs_q.pop_front());
        end
        if (cs_err) n_cs_err++;
        if (short_err) n_short++;
        hold_prev = out_valid && !out_ready;
        prev = got;
      end
    end
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [27:0] w;
    logic [191:0] cs_lit;
    int base, v0, e0, s0;
    logic [1:0] t;
    int n;
    bit fast;

    cs_lit = {96{2'b10}};
    rst = 1'b1; pre_valid = 1'b0; pre_type = 2'd3; vin = 1'b0; din = 1'b0;
    model_reset();
    wait_cyc(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_par_cnt", par_err_cnt, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_pulses", {cs_valid, cs_err, short_err}, 0);
    chk("rst_cs_data", 32'(|cs_data), 0);
    rst = 1'b0;
    rdy_fixed = 1;
    wait_cyc(2);

    // stereo pair with latency check on the first word
    w = mk(24'h123456, 1'b0, 1'b1, 1'b0);
    pre(2'd0);
    send_bits(w, 27, 1'b0);
    vin = 1'b1; din = w[27];
    @(posedge clk); #1;
    vin = 1'b0; din = 1'b0;
    model_commit(w);
    @(negedge clk);
    chk("lat_commit_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("stereo0_data", out_data, 32'h12345);
    chk("stereo0_ch_v_u", {out_ch, out_v, out_u}, 32'b0001);
    wait_cyc(2);
    pre(2'd2);
    send_bits(mk(24'hABCDEF, 1'b0, 1'b1, 1'b0), 28, 1'b0);
    drain("stereo_drain");
    chk("stereo1_word", got_log[$], {20'hABCDE, 2'd1, 1'b0, 1'b1});

    // parity failure in slot 10, then a good subframe
    base = got_log.size();
    pre(2'd1);
    send_bits(mk(24'($urandom()), 1'b0, 1'b0, 1'b0) ^ 28'h40, 28, 1'b0);
    sub(2'd1, 1'b0);
    drain("parity_drain");
    chk("parity_cnt", par_err_cnt, 1);
    chk("parity_words", got_log.size() - base, 1);

    // overflow: 19 good subframes into a stalled 16-entry FIFO
    rdy_fixed = 0;
    wait_cyc(3);
    for (int i = 0; i < 19; i++) sub(2'd1, 1'b0);
    wait_cyc(4);
    chk("ovf_cnt", ovf_cnt, 3);
    chk("ovf_valid", out_valid, 1);
    base = got_log.size();
    rdy_fixed = 1;
    drain("ovf_drain");
    chk("ovf_drained", got_log.size() - base, 16);

    // complete channel-status block with C = fidx[0] on channel 0
    rdy_rand = 1;
    v0 = n_cs_valid;
    for (int k = 0; k < 192; k++) begin
      sub((k == 0) ? 2'd0 : 2'd1, k[0]);
      sub(2'd2, 1'($urandom()));
    end
    wait_cyc(6);
    chk("cs_one_valid", n_cs_valid - v0, 1);
    checks++;
    if (cs_data !== cs_lit) begin
      errors++;
      $display("FAIL cs_data_literal got=%h exp=%h", cs_data, cs_lit);
    end

    // new block aborted by B at fidx 99
    v0 = n_cs_valid; e0 = n_cs_err;
    for (int k = 0; k < 100; k++) sub((k == 0) ? 2'd0 : 2'd1, 1'b1);
    sub(2'd0, 1'b0);
    wait_cyc(6);
    chk("cs_abort_err", n_cs_err - e0, 1);
    chk("cs_abort_no_valid", n_cs_valid - v0, 0);
    rdy_rand = 0; rdy_fixed = 1;
    drain("cs_drain");

    // truncation after 10 bits
    s0 = n_short; base = got_log.size();
    pre(2'd1);
    send_bits(mk(24'($urandom()), 1'b1, 1'b0, 1'b0), 10, 1'b0);
    pre(2'd2);
    send_bits(mk(24'($urandom()), 1'b1, 1'b0, 1'b0), 28, 1'b0);
    drain("trunc_drain");
    chk("trunc_short", n_short - s0, 1);
    chk("trunc_words", got_log.size() - base, 1);

    // channel sequence B,W,W,W,W on four channels
    sub(2'd0, 1'b0);
    for (int i = 0; i < 4; i++) sub(2'd2, 1'b0);
    drain("chseq_drain");
    chk("chseq", {got_log[got_log.size()-5].ch, got_log[got_log.size()-4].ch,
                  got_log[got_log.size()-3].ch, got_log[got_log.size()-2].ch,
                  got_log[got_log.size()-1].ch}, 32'b00_01_10_11_11);

    // asynchronous reset mid-subframe with two words queued
    rdy_fixed = 0;
    wait_cyc(3);
    sub(2'd1, 1'b0);
    sub(2'd1, 1'b0);
    pre(2'd1);
    send_bits(mk(24'($urandom()), 1'b0, 1'b0, 1'b0), 10, 1'b0);
    chk("pre_rst_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_par", par_err_cnt, 0);
    chk("async_rst_ovf", ovf_cnt, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    rdy_fixed = 1;
    wait_cyc(2);
    base = got_log.size();
    sub(2'd0, 1'b0);
    sub(2'd2, 1'b0);
    drain("post_rst_drain");
    chk("post_rst_words", got_log.size() - base, 2);

    // randomised traffic: all preamble types, truncations, parity errors, preambles in COMMIT
    rdy_rand = 1;
    for (int i = 0; i < 80; i++) begin
      t = 2'($urandom_range(0, 3));
      if (m_in_sub && t == 2'd3) t = 2'd2;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 27) : 28;
      w = mk(24'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
      if ($urandom_range(0, 5) == 0) w = w ^ (28'd1 << $urandom_range(0, 27));
      fast = ($urandom_range(0, 3) == 0);
      pre(t);
      send_bits(w, n, fast);
    end
    if (m_in_sub) sub(2'd1, 1'b0);
    rdy_rand = 0; rdy_fixed = 1;
    drain("final_drain");
    wait_cyc(4);
    chk("final_par_cnt", par_err_cnt, m_par);
    chk("final_ovf_cnt", ovf_cnt, m_ovf);
    chk("final_short", n_short, exp_short);
    chk("final_cs_err", n_cs_err, exp_cs_err);
    chk("final_cs_valid", n_cs_valid, exp_cs_valid);
    chk("final_cs_pending", cs_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
